// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int DEPTH_DEF  = 3;
    localparam int FWD_RF     = 0;

    // Fixed-width dst field; register addresses are zero-extended into it, so REG_AW must not exceed it
    localparam int TRK_DST_W  = 8;

    typedef struct packed {
        logic                 valid;
        logic [TRK_DST_W-1:0] dst;
        logic                 wen;
        logic                 load;
    } trk_entry_t;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - youngest-producer priority comparator for one source operand
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  trk_entry_t [DEPTH-1:0] pipe,
    input  logic [TRK_DST_W-1:0]   src,
    input  logic                   used,
    output logic [SEL_W-1:0]       sel,
    output logic                   is_load
);

    // Scan oldest to youngest so the lowest matching stage is the one left standing
    always_comb begin
        sel     = SEL_W'(FWD_RF);
        is_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (pipe[k-1].valid && pipe[k-1].wen && (pipe[k-1].dst == src) &&
                (src != '0) && used) begin
                sel     = SEL_W'(k);
                is_load = pipe[k-1].load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding select, load-use stall and branch flush for the post-ID stages
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wen,
    input  logic              id_load,
    input  logic              branch_taken,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    trk_entry_t [DEPTH-1:0] pipe_q;
    trk_entry_t             id_ent;
    logic [SEL_W-1:0]       sel_a;
    logic [SEL_W-1:0]       sel_b;
    logic                   load_a;
    logic                   load_b;
    logic                   load_use;

    hazard_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rs (
        .pipe    (pipe_q),
        .src     (TRK_DST_W'(id_rs)),
        .used    (id_rs_used),
        .sel     (sel_a),
        .is_load (load_a)
    );

    hazard_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rt (
        .pipe    (pipe_q),
        .src     (TRK_DST_W'(id_rt)),
        .used    (id_rt_used),
        .sel     (sel_b),
        .is_load (load_b)
    );

    // A load one stage ahead has no data yet; anything older can be forwarded
    assign load_use = ((sel_a == SEL_W'(1)) && load_a) || ((sel_b == SEL_W'(1)) && load_b);
    assign flush    = branch_taken;
    assign stall    = load_use && !branch_taken;
    assign fwd_a    = stall ? SEL_W'(FWD_RF) : sel_a;
    assign fwd_b    = stall ? SEL_W'(FWD_RF) : sel_b;

    always_comb begin
        id_ent       = '0;
        id_ent.valid = 1'b1;
        id_ent.dst   = TRK_DST_W'(id_dst);
        id_ent.wen   = id_wen;
        id_ent.load  = id_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            pipe_q[0] <= (id_valid && !stall && !flush) ? id_ent : '0;
            // Entries younger than the resolving branch are killed as they advance
            for (int k = 1; k < DEPTH; k++) begin
                pipe_q[k] <= (flush && (k < BR_STAGE)) ? '0 : pipe_q[k-1];
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table, directed and randomized checks of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int BR    = 2;
    localparam int CW    = 4;
    localparam int SW    = 2;
    localparam int CMAX  = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic [AW-1:0] id_dst;
    logic          id_wen;
    logic          id_load;
    logic          branch_taken;
    logic [SW-1:0] fwd_a;
    logic [SW-1:0] fwd_b;
    logic          stall;
    logic          flush;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    pipe_hazard_ctrl #(
        .REG_AW   (AW),
        .DEPTH    (DEPTH),
        .BR_STAGE (BR),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_dst       (id_dst),
        .id_wen       (id_wen),
        .id_load      (id_load),
        .branch_taken (branch_taken),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .flush        (flush),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rs;
        int rt;
        bit rsu;
        bit rtu;
        int dst;
        bit wen;
        bit ld;
        bit br;
        int efa;
        int efb;
        bit est;
        bit efl;
    } vec_t;

    typedef struct {
        bit v;
        int dst;
        bit wen;
        bit ld;
    } ment_t;

    // Model: element 0 is the youngest tracked instruction (stage 1)
    ment_t trk_q[$];
    int    m_scnt;
    int    m_fcnt;
    int    checks = 0;
    int    errors = 0;
    vec_t  tbl[$];

    function automatic vec_t mk(bit v, int rs, int rt, bit rsu, bit rtu, int dst, bit wen,
                                bit ld, bit br, int efa, int efb, bit est, bit efl);
        vec_t x;
        x.v = v; x.rs = rs; x.rt = rt; x.rsu = rsu; x.rtu = rtu; x.dst = dst;
        x.wen = wen; x.ld = ld; x.br = br; x.efa = efa; x.efb = efb; x.est = est; x.efl = efl;
        return x;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t x;
        x = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
               0, 0, 0, 0);
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ment_t b;
        b = '{v: 1'b0, dst: 0, wen: 1'b0, ld: 1'b0};
        trk_q.delete();
        repeat (DEPTH) trk_q.push_back(b);
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    function automatic void m_match(input int src, input bit used, output int stage, output bit is_ld);
        stage = 0;
        is_ld = 1'b0;
        if (used && src != 0) begin
            foreach (trk_q[i]) begin
                if (stage == 0 && trk_q[i].v && trk_q[i].wen && trk_q[i].dst == src) begin
                    stage = i + 1;
                    is_ld = trk_q[i].ld;
                end
            end
        end
    endfunction

    task automatic drive(input vec_t x);
        id_valid     = x.v;
        id_rs        = AW'(x.rs);
        id_rt        = AW'(x.rt);
        id_rs_used   = x.rsu;
        id_rt_used   = x.rtu;
        id_dst       = AW'(x.dst);
        id_wen       = x.wen;
        id_load      = x.ld;
        branch_taken = x.br;
    endtask

    // One cycle: drive at the falling edge, compare mid-cycle, advance the model for the coming rising edge
    task automatic step(input vec_t x, input bit use_tbl, input string tag);
        int    sa, sb;
        bit    la, lb, mst;
        int    efa, efb;
        bit    est, efl;
        ment_t ne;
        @(negedge clk);
        drive(x);
        #1;
        m_match(x.rs, x.rsu, sa, la);
        m_match(x.rt, x.rtu, sb, lb);
        mst = ((sa == 1 && la) || (sb == 1 && lb)) && !x.br;
        if (use_tbl) begin
            efa = x.efa; efb = x.efb; est = x.est; efl = x.efl;
        end else begin
            efa = mst ? 0 : sa; efb = mst ? 0 : sb; est = mst; efl = x.br;
        end
        check({tag, "_fwd_a"}, int'(fwd_a), efa);
        check({tag, "_fwd_b"}, int'(fwd_b), efb);
        check({tag, "_stall"}, int'(stall), int'(est));
        check({tag, "_flush"}, int'(flush), int'(efl));
        check({tag, "_stall_cnt"}, int'(stall_cnt), m_scnt);
        check({tag, "_flush_cnt"}, int'(flush_cnt), m_fcnt);
        ne = '{v: x.v && !mst && !x.br, dst: x.dst, wen: x.wen, ld: x.ld};
        trk_q.push_front(ne);
        void'(trk_q.pop_back());
        if (x.br) begin
            for (int i = 0; i < BR; i++) trk_q[i].v = 1'b0;
        end
        if (mst && m_scnt < CMAX) m_scnt++;
        if (x.br && m_fcnt < CMAX) m_fcnt++;
    endtask

    initial begin
        vec_t x;
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();

        // Reset held with random ID activity
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = rnd_vec();
            x.br = 1'b0;
            drive(x);
            #1;
            check("rst_stall", int'(stall), 0);
            check("rst_fwd_a", int'(fwd_a), 0);
            check("rst_fwd_b", int'(fwd_b), 0);
            check("rst_stall_cnt", int'(stall_cnt), 0);
            check("rst_flush_cnt", int'(flush_cnt), 0);
        end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        x = rnd_vec();
        x.v = 1'b0;
        x.br = 1'b0;
        step(x, 1'b0, "rel");

        //        v  rs rt rsu rtu dst wen ld br  fa fb st fl
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6, 5, 1, 1, 8, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6, 5, 1, 1, 8, 1, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8, 0, 1, 0, 9, 1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 7, 7, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 7, 0, 1, 0, 0, 1, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 10, 0, 1, 11, 1, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("tbl_end_stall_cnt", int'(stall_cnt), 1);
        check("tbl_end_flush_cnt", int'(flush_cnt), 1);

        // Twenty load-use stalls drive the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) begin
            step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0), 1'b0, "sat_ld");
            step(mk(1, 0, 5, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0), 1'b0, "sat_use");
        end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("sat_stall_cnt", int'(stall_cnt), CMAX);

        for (int i = 0; i < 300; i++) step(rnd_vec(), 1'b0, "rnd");

        // Asynchronous reset in mid-cycle with a live load-use hazard
        step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0), 1'b0, "mid_ld");
        @(negedge clk);
        drive(mk(1, 0, 5, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        #1;
        check("mid_pre_stall", int'(stall), 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_stall", int'(stall), 0);
        check("mid_rst_fwd_b", int'(fwd_b), 0);
        check("mid_rst_stall_cnt", int'(stall_cnt), 0);
        check("mid_rst_flush_cnt", int'(flush_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(mk(1, 0, 5, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0), 1'b1, "post_rst");
        for (int i = 0; i < DEPTH; i++) step(mk(0, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "drain");
        step(mk(0, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the MIPS pipeline. It replaces the fixed single-comparison hazard check and the separate `rst | branch` flush OR with one block. The block tracks the destination register of every in-flight instruction over `DEPTH` post-decode stages. From that tracking it produces:
- per-operand forwarding selects,
- a load-use stall,
- a branch flush that also kills the younger tracked entries.

It sits beside the ID stage. It feeds the IF/ID and ID/EX pipeline-register enables and clears, and the EX-stage operand muxes.

## Interface
- `REG_AW`, 5, register address width
- `DEPTH`, 3, tracked stages after ID (1 = EX, 2 = MEM, 3 = WB)
- `BR_STAGE`, 2, stage index at which `branch_taken` is resolved (1..DEPTH)
- `CNT_W`, 16, width of the performance counters
- `SEL_W`, $clog2(DEPTH+1), forwarding-select width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`  in  REG_AW  source register addresses
- `id_rs_used`, `id_rt_used`  in  1  the source is actually read
- `id_dst`  in  REG_AW  destination register
- `id_wen`  in  1  the instruction writes `id_dst`
- `id_load`  in  1  the instruction is a load
- `branch_taken`  in  1  branch in stage `BR_STAGE` is taken this cycle
- `fwd_a`, `fwd_b`  out  SEL_W  0 = register file, k = forward from stage k
- `stall`  out  1  hold PC and IF/ID, insert a bubble into ID/EX
- `flush`  out  1  clear IF/ID and ID/EX on the next edge
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters

## Operation
- Tracking pipe: entries `{valid, dst, wen, load}` for stages 1..DEPTH, shifted every cycle (stage k+1 <= stage k).
- Stage-1 entry:
  - The ID entry is loaded when `id_valid & !stall & !flush`.
  - Otherwise a bubble is loaded (`valid` = 0).
- Match rule for source s against stage k: `valid & wen & dst == s & s != 0 & s_used`.
- Forwarding:
  - `fwd_x` = the lowest matching k (youngest producer wins).
  - `fwd_x` = 0 when nothing matches.
- Load-use:
  - If the lowest match for either source is stage 1 with `load` = 1, assert `stall`.
  - While `stall` is high, `fwd_a` and `fwd_b` are forced to 0.
  - A load matched at stage ≥ 2 forwards normally.
- Flush:
  - `flush = branch_taken`.
  - On that edge, tracked stages 1..BR_STAGE-1 are cleared to bubbles.
  - Stages ≥ BR_STAGE shift normally.
- Priority: `flush` overrides `stall`. When `branch_taken` is high, `stall` = 0 and the counters do not record a stall.
- Counters:
  - `stall_cnt` increments on each cycle with `stall` = 1.
  - `flush_cnt` increments on each cycle with `flush` = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, `rst` = 0):
  - All entry `valid` bits = 0.
  - Both counters = 0.
  - As a consequence `fwd_a` = `fwd_b` = 0 and `stall` = 0.
  - `flush` = `branch_taken`, which is 0 under a correct reset.
- Reset mid-operation discards every tracked entry immediately. The first instruction after release sees no hazards.
- `fwd_*`, `stall` and `flush` are combinational from the registered pipe plus the current ID inputs, with zero-cycle latency.
- Load-use stall lasts exactly one cycle. On the next edge the load moves to stage 2 and the held instruction forwards from stage 2.
- Back-to-back loads feeding each other each stall one cycle.
- After DEPTH idle cycles the pipe is empty and all selects are 0.
- Register 0 never produces a match, stall or forward, regardless of `wen`.

## Structure
- Shared package `hazard_pkg` contains:
  - the `trk_entry_t` struct `{valid, dst, wen, load}`;
  - `FWD_RF` = 0;
  - the default `REG_AW` and `DEPTH` constants.
- One sub-module, `hazard_match`, holds the per-source priority comparator over the DEPTH entries. It returns the match stage index and a load flag and is instantiated twice (rs, rt).

## Test plan
- **Reset:** hold `rst` = 0 with random ID inputs -> `stall` = 0, `fwd_a` = `fwd_b` = 0, both counters 0. Release `rst` -> same outputs until an instruction issues.
- **ALU chain:** issue `add $3` then `sub` reading `$3` -> `fwd_a` = 1. Issue it one cycle later -> `fwd_a` = 2. Two cycles later -> `fwd_a` = 3. Three cycles later -> `fwd_a` = 0.
- **Load-use:** issue `lw $5`, then an instruction reading `$5` in rt -> `stall` = 1 for one cycle and `stall_cnt` = 1. The next cycle gives `fwd_b` = 2 and `stall` = 0.
- **Youngest wins and `$0`:**
  - Two writers of `$7` at stages 1 and 3 -> `fwd` = 1.
  - A writer of `$0` with `wen` = 1 -> no forward, no stall.
- **Flush:** with `BR_STAGE` = 2, raise `branch_taken` while a load-use stall condition is present -> `flush` = 1, `stall` = 0, `flush_cnt` = 1. Stage-1 entry cleared: a later reader of its dst gets `fwd` = 0.
- **Saturation:** run with `CNT_W` = 4 and a 20-cycle repeated stall -> `stall_cnt` holds at 15.
